// File: rtl/serial_shift_io_if.sv
// Host-side bundle for serial_shift_io: parallel word, frame request
// and completion status between the I/O register block and the driver.
interface serial_shift_io_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             start;
  logic             auto_en;
  logic             busy;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;

  modport master (
    output tx_data,
    output start,
    output auto_en,
    input  busy,
    input  rx_data,
    input  rx_valid
  );

  modport slave (
    input  tx_data,
    input  start,
    input  auto_en,
    output busy,
    output rx_data,
    output rx_valid
  );
endinterface

// File: rtl/serial_shift_io.sv
// Full-duplex driver for daisy-chained 595/165 shift registers with
// host-triggered and periodic auto-refresh frames.
module serial_shift_io #(
  parameter int WIDTH          = 8,
  parameter int CLK_DIV        = 1024,
  parameter int REFRESH_CYCLES = 2097152,
  parameter bit MSB_FIRST      = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_shift_io_if.slave host,
  output logic             sclk,
  output logic             sdata_out,
  input  logic             sdata_in,
  output logic             frame,
  output logic             latch
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RW =
    (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_div_cnt;
  logic [BW-1:0]   r_bit_cnt;
  logic [RW-1:0]   r_ref_cnt;
  logic            r_phase;
  logic [WIDTH-1:0] r_tx_shift;
  logic [WIDTH-1:0] r_rx_shift;

  logic            w_trig;
  logic            w_div_end;
  logic            w_go;
  logic            w_sample;
  logic            w_adv;
  logic            w_end_shift;
  logic            w_done;
  logic [BW-1:0]   w_bit_nxt;

  // k-th bit on the wire maps to the same word index both ways
  function automatic logic [BW-1:0] pos(input logic [BW-1:0] k);
    return MSB_FIRST ? (BIT_LAST - k) : k;
  endfunction

  assign w_trig = host.start |
    (host.auto_en & (r_ref_cnt == REF_LAST));
  assign w_div_end = (r_div_cnt == DIV_LAST);
  assign w_bit_nxt = r_bit_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_sample    = 1'b0;
    w_adv       = 1'b0;
    w_end_shift = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_trig) begin
          w_go        = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_div_end) begin
          if (!r_phase) begin
            w_sample = 1'b1;
          end else if (r_bit_cnt != BIT_LAST) begin
            w_adv = 1'b1;
          end else begin
            w_end_shift = 1'b1;
            w_state_nxt = LATCH;
          end
        end
      end
      LATCH: begin
        if (w_div_end) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_ref_cnt     <= '0;
      r_phase       <= 1'b0;
      r_tx_shift    <= '0;
      r_rx_shift    <= '0;
      sclk          <= 1'b0;
      sdata_out     <= 1'b0;
      frame         <= 1'b0;
      latch         <= 1'b0;
      host.busy     <= 1'b0;
      host.rx_data  <= '0;
      host.rx_valid <= 1'b0;
    end else begin
      host.rx_valid <= 1'b0;
      if (r_ref_cnt != REF_LAST) begin
        r_ref_cnt <= r_ref_cnt + 1'b1;
      end
      if (r_state != IDLE) begin
        r_div_cnt <= w_div_end ? '0 : r_div_cnt + 1'b1;
      end
      if (w_go) begin
        r_tx_shift <= host.tx_data;
        r_bit_cnt  <= '0;
        r_div_cnt  <= '0;
        r_phase    <= 1'b0;
        r_ref_cnt  <= '0;
        host.busy  <= 1'b1;
        frame      <= 1'b1;
        sdata_out  <= host.tx_data[pos('0)];
      end
      if (w_sample) begin
        sclk    <= 1'b1;
        r_phase <= 1'b1;
        r_rx_shift[pos(r_bit_cnt)] <= sdata_in;
      end
      if (w_adv) begin
        sclk      <= 1'b0;
        r_phase   <= 1'b0;
        r_bit_cnt <= w_bit_nxt;
        sdata_out <= r_tx_shift[pos(w_bit_nxt)];
      end
      // data line is held through LATCH
      if (w_end_shift) begin
        sclk    <= 1'b0;
        r_phase <= 1'b0;
        frame   <= 1'b0;
        latch   <= 1'b1;
      end
      if (w_done) begin
        latch         <= 1'b0;
        host.busy     <= 1'b0;
        host.rx_data  <= r_rx_shift;
        host.rx_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_shift_io.sv
// Randomized bench for serial_shift_io: frame-level reference model
// built from the wire protocol, plus directed refresh/reset cases.
module tb_serial_shift_io;

  localparam int W  = 8;
  localparam int CD = 2;
  localparam int RC = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_shift_io_if #(.WIDTH(W)) h0 ();
  serial_shift_io_if #(.WIDTH(W)) h1 ();

  logic sclk0, sdo0, sdi0, frame0, latch0;
  logic sclk1, sdo1, frame1, latch1;
  logic loop = 1'b0;
  logic rnd  = 1'b0;

  assign sdi0 = loop ? sdo0 : rnd;

  serial_shift_io #(
    .WIDTH(W), .CLK_DIV(CD),
    .REFRESH_CYCLES(RC), .MSB_FIRST(1'b0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .host(h0),
    .sclk(sclk0), .sdata_out(sdo0), .sdata_in(sdi0),
    .frame(frame0), .latch(latch0)
  );

  serial_shift_io #(
    .WIDTH(W), .CLK_DIV(CD),
    .REFRESH_CYCLES(RC), .MSB_FIRST(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .host(h1),
    .sclk(sclk1), .sdata_out(sdo1), .sdata_in(sdo1),
    .frame(frame1), .latch(latch1)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // LSB-first: wire bit k is word bit k
  function automatic logic bit_of(input logic [7:0] w, input int k);
    return logic'((w >> k) & 8'd1);
  endfunction

  int cyc = 0, n_rise = 0, last_rise = 0, prev_rise = 0;
  int blen = 0, flen = 0, llen = 0, hlen = 0, nbits = 0;
  logic [7:0] word = '0, rxw = '0;
  logic p_busy = 0, p_sclk = 0, p_sdo = 0, p_sdi = 0;
  logic p_frame = 0, p_latch = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      check("rx_valid", h0.rx_valid, !h0.busy && p_busy);
      if (h0.busy && !p_busy) begin
        n_rise++;
        prev_rise = last_rise;
        last_rise = cyc;
        word  = h0.tx_data;
        rxw   = '0;
        nbits = 0;
        blen  = 0;
      end
      if (h0.busy) blen++;
      if (sclk0 && !p_sclk) begin
        check("tx_bit", sdo0, bit_of(word, nbits));
        check("tx_setup", sdo0, p_sdo);
        rxw = rxw | (8'(p_sdi) << nbits);
        nbits++;
        hlen = 0;
      end
      if (sclk0) hlen++;
      if (!sclk0 && p_sclk) check("sclk_high", hlen, CD);
      if (frame0 && !p_frame) flen = 0;
      if (frame0) flen++;
      if (!frame0 && p_frame) begin
        check("frame_len", flen, 2 * CD * W);
        check("latch_rise", latch0, 1'b1);
        llen = 0;
      end
      if (latch0) llen++;
      if (!latch0 && p_latch) check("latch_len", llen, CD);
      if (!h0.busy && p_busy) begin
        check("busy_len", blen, 2 * CD * W + CD);
        check("sclk_pulses", nbits, W);
        check("rx_data", h0.rx_data, rxw);
      end
    end
    p_busy  = rst_n & h0.busy;
    p_sclk  = sclk0;
    p_sdo   = sdo0;
    p_frame = frame0;
    p_latch = latch0;
    rnd     = 1'($urandom);
    p_sdi   = loop ? sdo0 : rnd;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic v, input int budget,
                           input string tag);
    int n = 0;
    while (h0.busy !== v && n < budget) begin
      tick();
      n++;
    end
    check(tag, h0.busy, v);
  endtask

  task automatic wait_rise(input int budget);
    int n0 = n_rise;
    int n = 0;
    while (n_rise == n0 && n < budget) begin
      tick();
      n++;
    end
    check("rise_wait", n_rise != n0, 1'b1);
  endtask

  task automatic host_frame(input logic [7:0] d);
    h0.tx_data = d;
    h0.start = 1'b1;
    tick();
    h0.start = 1'b0;
    wait_busy(1'b0, 60, "frame_end");
  endtask

  initial begin
    int gap, n, k;
    h0.tx_data = '0; h0.start = 0; h0.auto_en = 0;
    h1.tx_data = '0; h1.start = 0; h1.auto_en = 0;
    repeat (3) tick();
    check("rst_busy", h0.busy, 1'b0);
    check("rst_sclk", sclk0, 1'b0);
    check("rst_sdo", sdo0, 1'b0);
    check("rst_frame", frame0, 1'b0);
    check("rst_latch", latch0, 1'b0);
    check("rst_rxd", h0.rx_data, 8'h00);
    check("rst_rxv", h0.rx_valid, 1'b0);
    rst_n = 1'b1;
    tick();

    h0.tx_data = 8'h5A;
    h0.start = 1'b1;
    tick();
    h0.start = 1'b0;
    repeat (9) tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_busy", h0.busy, 1'b0);
    check("mid_sclk", sclk0, 1'b0);
    check("mid_sdo", sdo0, 1'b0);
    check("mid_frame", frame0, 1'b0);
    check("mid_latch", latch0, 1'b0);
    check("mid_rxv", h0.rx_valid, 1'b0);
    check("mid_rxd", h0.rx_data, 8'h00);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("post_rst_idle", h0.busy, 1'b0);
    host_frame(8'hC3);

    tick();
    host_frame(8'hA5);
    check("a5_rxv_at_fall", h0.rx_valid, 1'b1);
    tick();
    check("a5_rxv_single", h0.rx_valid, 1'b0);

    loop = 1'b1;
    host_frame(8'h3C);
    check("loop_rxv", h0.rx_valid, 1'b1);
    check("loop_rxd", h0.rx_data, 8'h3C);
    loop = 1'b0;

    repeat (6) begin
      loop = 1'($urandom);
      host_frame(8'($urandom));
      repeat ($urandom_range(1, 5)) tick();
    end
    loop = 1'b0;

    h0.tx_data = 8'($urandom);
    h0.start = 1'b1;
    wait_rise(10);
    for (int f = 0; f < 3; f++) begin
      repeat (5) tick();
      h0.tx_data = 8'($urandom);
      wait_busy(1'b0, 60, "b2b_end");
      gap = 0;
      while (!h0.busy && gap < 10) begin
        tick();
        gap++;
      end
      check("b2b_gap", gap, 1);
    end
    h0.start = 1'b0;
    wait_busy(1'b0, 60, "b2b_last");

    h0.auto_en = 1'b1;
    wait_rise(200);
    wait_rise(150);
    check("auto_period", last_rise - prev_rise, RC);
    repeat (10) tick();
    h0.start = 1'b1;
    tick();
    h0.start = 1'b0;
    wait_rise(150);
    check("auto_ignore_start", last_rise - prev_rise, RC);
    repeat (99) tick();
    h0.start = 1'b1;
    tick();
    h0.start = 1'b0;
    check("same_cycle_busy", h0.busy, 1'b1);
    check("same_cycle_period", last_rise - prev_rise, RC);
    n = n_rise;
    wait_busy(1'b0, 60, "same_cycle_end");
    repeat (20) tick();
    check("same_cycle_single", n_rise, n);
    h0.auto_en = 1'b0;

    for (int f = 0; f < 3; f++) begin
      logic [7:0] d;
      d = (f == 0) ? 8'h80 : 8'($urandom);
      h1.tx_data = d;
      h1.start = 1'b1;
      tick();
      h1.start = 1'b0;
      k = 0;
      while (!sclk1 && k < 20) begin
        tick();
        k++;
      end
      check("msb_first_bit", sdo1, d[7]);
      k = 0;
      while (h1.busy && k < 60) begin
        tick();
        k++;
      end
      check("msb_rxv", h1.rx_valid, 1'b1);
      check("msb_rxd", h1.rx_data, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
